// File: rtl/seq_ntt_engine.sv
// Sequential N-point NTT/INTT engine: one modular multiply-accumulate per cycle,
// start/done handshake, run-time modulus and forward/inverse selection.
module seq_ntt_engine #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [N*W-1:0] data_in,
    input  logic [W-1:0]   omega,
    input  logic [W-1:0]   inv_omega,
    input  logic [W-1:0]   inv_n,
    input  logic [W-1:0]   mod,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N*W-1:0] data_out
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_STORE, S_DONE} state_t;

    state_t         state_q;
    logic           mode_q;
    logic [W-1:0]   q_q, r_q, ninv_q;
    logic [W-1:0]   x_q    [N];
    logic [W-1:0]   obuf_q [N];
    logic [CW-1:0]  j_q, k_q;
    logic [W-1:0]   acc_q, tw_q, wk_q;
    logic           busy_q, done_q, err_q;
    logic [N*W-1:0] dout_q;

    logic [W-1:0]   xin_d [N];
    logic [W-1:0]   mac_d, tw_d, wk_d, store_d;
    logic [N*W-1:0] dout_d;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return (m == '0) ? '0 : W'(p % (2*W)'(m));
    endfunction

    // Both operands are already < m, so a single conditional subtract is exact.
    function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return W'(s);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            xin_d[i] = (mod < W'(2)) ? '0 : data_in[i*W +: W] % mod;
        end
        mac_d   = addmod(acc_q, mulmod(x_q[j_q], tw_q, q_q), q_q);
        tw_d    = mulmod(tw_q, wk_q, q_q);
        wk_d    = mulmod(wk_q, r_q, q_q);
        store_d = mode_q ? mulmod(acc_q, ninv_q, q_q) : acc_q;
        dout_d  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            dout_d[i*W +: W] = obuf_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ninv_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]    <= '0;
                obuf_q[i] <= '0;
            end
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            tw_q    <= '0;
            wk_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        q_q    <= mod;
                        r_q    <= mode ? inv_omega : omega;
                        ninv_q <= inv_n;
                        for (int unsigned i = 0; i < N; i++) begin
                            x_q[i] <= xin_d[i];
                        end
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                        tw_q    <= W'(1);
                        wk_q    <= W'(1);
                        busy_q  <= 1'b1;
                        state_q <= (mod < W'(2)) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= mac_d;
                    tw_q  <= tw_d;
                    j_q   <= j_q + 1'b1;
                    if (j_q == CW'(N - 1)) state_q <= S_STORE;
                end
                S_STORE: begin
                    obuf_q[k_q] <= store_d;
                    wk_q        <= wk_d;
                    acc_q       <= '0;
                    tw_q        <= W'(1);
                    j_q         <= '0;
                    if (k_q == CW'(N - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_DONE: begin
                    dout_q  <= (q_q < W'(2)) ? '0 : dout_d;
                    err_q   <= (q_q < W'(2));
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = dout_q;

endmodule
